// File: rtl/seg_scan_ctrl_if.sv
// Display-image load channel: a source offers a 16-bit hex value plus
// per-digit decimal points; the scan controller accepts when its pending slot is empty.
interface seg_scan_ctrl_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic [3:0]  load_dots;

  modport master (output load_valid, load_value, load_dots, input load_ready);
  modport slave  (input load_valid, load_value, load_dots, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered image,
// per-phase brightness PWM and frame-boundary commit.
module seg_scan_ctrl #(
  parameter int unsigned DWELL = 1024,
  parameter int unsigned BLANK = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  seg_scan_ctrl_if.slave  ld,
  input  logic [2:0]      brightness,
  output logic [7:0]      seg,
  output logic [3:0]      digit_en,
  output logic            frame_start
);

  localparam int unsigned CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned STEP    = DWELL / 8;

  typedef enum logic {BLNK = 1'b0, ON = 1'b1} state_t;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dots;
  } image_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bright_q, bright_d;
  image_t           active_q, active_d;
  image_t           pending_q, pending_d;
  logic             ready_q, ready_d;
  logic [7:0]       seg_d;
  logic [3:0]       digit_en_d;
  logic             frame_start_d;
  logic [CNT_W-1:0] lit_limit;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign ld.load_ready = ready_q;

  // Next state, then outputs decoded from that next state so seg/digit_en are plain flops
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    cnt_d         = cnt_q + CNT_W'(1);
    bright_d      = bright_q;
    active_d      = active_q;
    pending_d     = pending_q;
    ready_d       = ready_q;
    frame_start_d = 1'b0;
    seg_d         = 8'hFF;
    digit_en_d    = 4'b0000;

    case (state_q)
      BLNK: begin
        if (cnt_q == CNT_W'(BLANK - 1)) begin
          state_d  = ON;
          cnt_d    = '0;
          bright_d = brightness;
        end
      end
      ON: begin
        if (cnt_q == CNT_W'(DWELL - 1)) begin
          state_d = BLNK;
          cnt_d   = '0;
          slot_d  = slot_q + 2'd1;
          // Last ON cycle of slot 3 is the frame boundary: swap in a pending image
          if (slot_q == 2'd3) begin
            frame_start_d = 1'b1;
            if (!ready_q) begin
              active_d  = pending_q;
              pending_d = '0;
              ready_d   = 1'b1;
            end
          end
        end
      end
      default: state_d = BLNK;
    endcase

    // Only possible when pending is empty, so it never collides with a commit
    if (ld.load_valid && ready_q) begin
      pending_d = image_t'{value: ld.load_value, dots: ld.load_dots};
      ready_d   = 1'b0;
    end

    lit_limit = CNT_W'((32'(bright_d) + 32'd1) * STEP);
    if (state_d == ON) begin
      seg_d = {~active_d.dots[~slot_d], hex7(active_d.value[{~slot_d, 2'b00} +: 4])};
      if (cnt_d < lit_limit) digit_en_d[~slot_d] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= BLNK;
      slot_q      <= 2'd0;
      cnt_q       <= '0;
      bright_q    <= 3'd0;
      active_q    <= '0;
      pending_q   <= '0;
      ready_q     <= 1'b1;
      seg         <= 8'hFF;
      digit_en    <= 4'b0000;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      bright_q    <= bright_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      ready_q     <= ready_d;
      seg         <= seg_d;
      digit_en    <= digit_en_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues one expected record per ON
// phase; a negedge monitor measures each displayed phase and compares.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  localparam int unsigned DWELL = 16;
  localparam int unsigned BLANK = 2;
  localparam int unsigned FRAME = 4 * (DWELL + BLANK);

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [2:0] brightness;
  logic [7:0] seg;
  logic [3:0] digit_en;
  logic       frame_start;

  seg_scan_ctrl_if ld();

  seg_scan_ctrl #(.DWELL(DWELL), .BLANK(BLANK)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .ld          (ld),
    .brightness  (brightness),
    .seg         (seg),
    .digit_en    (digit_en),
    .frame_start (frame_start)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] de;
    logic [7:0] seg;
    int         lit;
    logic       fs;
    logic       chk_blank;
  } phase_t;

  phase_t exp_q[$];
  int     n_chk  = 0;
  int     n_fail = 0;

  // Monitor state
  bit         in_on    = 1'b0;
  int         on_len   = 0;
  int         lit_cnt  = 0;
  int         blank_len = 0;
  bit         fs_seen  = 1'b0;
  int         since_fs = -1;
  logic [7:0] cur_seg  = 8'h00;
  logic [3:0] cur_de   = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'h0: pat = 7'b1000000;  4'h1: pat = 7'b1111001;
      4'h2: pat = 7'b0100100;  4'h3: pat = 7'b0110000;
      4'h4: pat = 7'b0011001;  4'h5: pat = 7'b0010010;
      4'h6: pat = 7'b0000010;  4'h7: pat = 7'b1111000;
      4'h8: pat = 7'b0000000;  4'h9: pat = 7'b0010000;
      4'hA: pat = 7'b0001000;  4'hB: pat = 7'b0000011;
      4'hC: pat = 7'b1000110;  4'hD: pat = 7'b0100001;
      4'hE: pat = 7'b0000110;  default: pat = 7'b0001110;
    endcase
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input int lit0,
                            input int lit_rest, input logic fs, input logic chk_first,
                            input int nslots);
    for (int k = 0; k < nslots; k++) begin
      phase_t     r;
      logic [15:0] t;
      t           = v >> (12 - 4 * k);
      r.de        = 4'b1000 >> k;
      r.seg       = {~d[3-k], pat(t[3:0])};
      r.lit       = (k == 0) ? lit0 : lit_rest;
      r.fs        = (k == 0) ? fs : 1'b0;
      r.chk_blank = (k == 0) ? chk_first : 1'b1;
      exp_q.push_back(r);
    end
  endtask

  task automatic end_phase();
    phase_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_phase: de=%b seg=%h with no expectation", cur_de, cur_seg);
    end else begin
      e = exp_q.pop_front();
      check("phase_digit_en", 32'(cur_de), 32'(e.de));
      check("phase_seg", 32'(cur_seg), 32'(e.seg));
      check("phase_lit_cycles", lit_cnt, e.lit);
      check("phase_on_len", on_len, DWELL);
      check("phase_frame_start", 32'(fs_seen), 32'(e.fs));
      if (e.chk_blank) check("phase_blank_len", blank_len, BLANK);
    end
    blank_len = 0;
    fs_seen   = 1'b0;
  endtask

  // Monitor: reconstructs each ON phase from the pins
  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        in_on     = 1'b0;
        blank_len = 0;
        fs_seen   = 1'b0;
        since_fs  = -1;
      end else begin
        check("one_hot", 32'($countones(digit_en) <= 1), 32'd1);
        if (since_fs >= 0) since_fs++;
        if (frame_start) begin
          if (since_fs >= 0) check("frame_period", since_fs, FRAME);
          since_fs = 0;
        end
        if (seg == 8'hFF) begin
          check("blank_digit_en", 32'(digit_en), 32'd0);
          if (in_on) end_phase();
          in_on = 1'b0;
          blank_len++;
          if (frame_start) fs_seen = 1'b1;
        end else begin
          if (in_on) begin
            check("seg_stable", 32'(seg), 32'(cur_seg));
          end else begin
            in_on   = 1'b1;
            on_len  = 0;
            lit_cnt = 0;
            cur_seg = seg;
            cur_de  = 4'h0;
          end
          on_len++;
          if (digit_en != 4'h0) begin
            lit_cnt++;
            cur_de = digit_en;
          end
        end
      end
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, output logic fs_at);
    bit done;
    done  = 1'b0;
    fs_at = 1'b0;
    ld.load_valid = 1'b1;
    ld.load_value = v;
    ld.load_dots  = d;
    for (int i = 0; i < 4 * FRAME && !done; i++) begin
      if (ld.load_ready) begin
        fs_at = frame_start;
        done  = 1'b1;
        @(posedge CLK);
        #1;
        ld.load_valid = 1'b0;
        check("ready_drop", 32'(ld.load_ready), 32'd0);
      end else begin
        @(negedge CLK);
      end
    end
    if (!done) begin
      ld.load_valid = 1'b0;
      fail("load_accept");
    end
  endtask

  task automatic wait_fs(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      @(negedge CLK);
      if (frame_start) seen = 1'b1;
    end
    if (!seen) fail(name);
  endtask

  task automatic wait_sig(input string name, input logic [3:0] de_want, input bit any_on);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      @(negedge CLK);
      if (any_on ? (seg != 8'hFF) : (digit_en == de_want)) seen = 1'b1;
    end
    if (!seen) fail(name);
  endtask

  initial begin : stimulus
    logic fs_at;
    ld.load_valid = 1'b0;
    ld.load_value = 16'h0000;
    ld.load_dots  = 4'h0;
    brightness    = 3'd7;
    RST_N         = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_digit_en", 32'(digit_en), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_load_ready", 32'(ld.load_ready), 32'd1);

    // Frame 0 shows the reset image; the load during it lands in frame 1
    @(negedge CLK);
    RST_N = 1'b1;
    push_frame(16'h0000, 4'b0000, 16, 16, 1'b0, 1'b0, 4);
    repeat (3) @(negedge CLK);
    push_frame(16'h1A3F, 4'b0100, 16, 16, 1'b1, 1'b1, 4);
    do_load(16'h1A3F, 4'b0100, fs_at);

    wait_fs("fs_frame1");
    check("ready_after_commit", 32'(ld.load_ready), 32'd1);

    // Dim frame, then a mid-ON brightness raise that only affects later phases
    wait_fs("fs_frame2");
    brightness = 3'd0;
    push_frame(16'h1A3F, 4'b0100, 2, 2, 1'b1, 1'b1, 4);
    wait_fs("fs_frame3");
    push_frame(16'h1A3F, 4'b0100, 2, 16, 1'b1, 1'b1, 4);
    wait_sig("on_frame3", 4'h0, 1'b1);
    repeat (8) @(negedge CLK);
    brightness = 3'd7;

    // Back-to-back loads: second stalls until the cycle after the commit
    wait_fs("fs_frame4");
    push_frame(16'h1A3F, 4'b0100, 16, 16, 1'b1, 1'b1, 4);
    do_load(16'h2345, 4'b0001, fs_at);
    do_load(16'hBEEF, 4'b1000, fs_at);
    check("second_accept_at_boundary", 32'(fs_at), 32'd1);
    push_frame(16'h2345, 4'b0001, 16, 16, 1'b1, 1'b1, 4);
    push_frame(16'hBEEF, 4'b1000, 16, 16, 1'b1, 1'b1, 4);

    wait_fs("fs_frame6");
    do_load(16'h1A3F, 4'b0100, fs_at);
    push_frame(16'h1A3F, 4'b0100, 16, 16, 1'b1, 1'b1, 2);

    // Reset in the middle of slot 2 ON discards everything immediately
    wait_fs("fs_frame7");
    wait_sig("slot2_on", 4'b0010, 1'b0);
    repeat (4) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_seg", 32'(seg), 32'hFF);
    check("async_rst_digit_en", 32'(digit_en), 32'd0);
    check("async_rst_frame_start", 32'(frame_start), 32'd0);
    check("async_rst_load_ready", 32'(ld.load_ready), 32'd1);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    push_frame(16'h0000, 4'b0000, 16, 16, 1'b0, 1'b0, 4);
    push_frame(16'h0000, 4'b0000, 16, 16, 1'b1, 1'b1, 4);
    @(negedge CLK);
    check("ready_after_reset", 32'(ld.load_ready), 32'd1);

    for (int i = 0; i < 3 * FRAME && exp_q.size() != 0; i++) @(negedge CLK);
    check("queue_drained", exp_q.size(), 0);
    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL, default 1024: ON-phase length per digit in clock cycles; multiple of 8, minimum 8.
REQ-002 The block SHALL have parameter BLANK, default 16: inter-digit blanking length in clock cycles; minimum 1.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port load_valid, input, 1 bit: a new display image is offered.
REQ-006 The block SHALL have port load_ready, output, 1 bit: the pending slot is empty; a load is accepted when load_valid and load_ready are both high on a rising edge.
REQ-007 The block SHALL have port load_value, input, 16 bits: four hex nibbles; [15:12] is the leftmost digit.
REQ-008 The block SHALL have port load_dots, input, 4 bits: decimal point per digit; bit i belongs to the digit driven by digit_en[i].
REQ-009 The block SHALL have port brightness, input, 3 bits: duty level, 0 = dimmest, 7 = full.
REQ-010 The block SHALL have port seg, output, 8 bits: active-low segments; [6:0] = g..a, [7] = decimal point.
REQ-011 The block SHALL have port digit_en, output, 4 bits: active-high digit select; digit_en[3] = leftmost digit.
REQ-012 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-013 Digit slot k = 0..3 SHALL display nibble load_value[15-4k:12-4k] on digit_en[3-k] and dot bit 3-k.
REQ-014 The sequencer SHALL have two states: BLNK and ON. BLNK lasts BLANK cycles, then goes to ON. ON lasts DWELL cycles, then goes to BLNK of slot (k+1) mod 4.
REQ-015 The frame period SHALL be exactly 4*(BLANK+DWELL) cycles, with no idle cycles.
REQ-016 In BLNK, seg SHALL be 8'hFF and digit_en SHALL be 4'b0000.
REQ-017 In ON, seg SHALL be {~dot, pattern(nibble)}, using the hex table:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-018 In ON, digit_en[3-k] SHALL be high only while on_cnt < (brightness_lat+1)*(DWELL/8); all other digit_en bits SHALL be low. on_cnt runs 0..DWELL-1.
REQ-019 brightness_lat SHALL be sampled from brightness on the first cycle of each ON phase and held for that phase.
REQ-020 At most one digit_en bit SHALL be high in any cycle.
REQ-021 seg and digit_en SHALL be decoded from registered state only, with no combinational path from any input.
REQ-022 The block SHALL hold two image registers, active and pending (value + dots); the display SHALL always use active.
REQ-023 An accepted load SHALL write pending and drive load_ready low from the next cycle.
REQ-024 load_valid while load_ready is low SHALL be ignored; the source holds the request until it is accepted.
REQ-025 The commit cycle SHALL be the last ON cycle of slot 3.
- If pending is full, active <= pending and pending is cleared on that edge.
- frame_start SHALL be high in the following cycle, which is the first BLNK cycle of slot 0.
- load_ready SHALL be high from that following cycle.
REQ-026 A load accepted in the commit cycle SHALL go into pending and SHALL be committed at the next frame boundary, not the current one.
REQ-027 Loads SHALL never change the image mid-frame: all four digits of one frame come from the same image.
REQ-028 frame_start SHALL pulse on every frame boundary, whether or not a commit occurs.
REQ-029 frame_start SHALL NOT pulse for the first frame after reset.

Reset
REQ-030 While RST_N is low, regardless of CLK, the outputs SHALL be: seg=8'hFF, digit_en=0, frame_start=0, load_ready=1.
REQ-031 While RST_N is low, state SHALL be: BLNK, slot 0, all counters 0, active value/dots = 0, pending empty.
REQ-032 On RST_N release, the first BLNK cycle of slot 0 SHALL begin at the first rising edge.
REQ-033 Reset mid-operation SHALL discard both active and pending images.

Verification (DWELL=16, BLANK=2, brightness=7 unless stated)
REQ-034 Reset release, no loads: each frame is 72 cycles; digit_en walks 1000, 0100, 0010, 0001 with seg=8'hC0 during ON; seg=FF/digit_en=0 during BLNK.
REQ-035 Load value=16'h1A3F, dots=4'b0100 during frame 0: frame 0 still shows 0000; frame 1 shows F9 on digit_en=1000, 08 on 0100, B0 on 0010, 8E on 0001; frame_start pulses at the frame-1 start.
REQ-036 brightness=0: digit_en high for 2 of 16 ON cycles per slot (on_cnt 0-1). Change to 7 mid-ON: takes effect in the next ON phase (16 cycles).
REQ-037 Two back-to-back loads: load_ready drops after the first; the second is stalled until the cycle after the commit, is accepted then, and is displayed one frame later.
REQ-038 RST_N low during slot 2 ON after a commit of 16'h1A3F: seg=FF and digit_en=0 immediately; after release, the next frame shows 0000 (C0) and load_ready=1.
